// File: rtl/de0_cv_pll_reset_seq.sv
// Reset/lock sequencer for the system PLL: pulses pll_rst, qualifies the
// asynchronous locked signal over a stability window, releases the per-domain
// resets in staggered order and re-sequences on loss of lock. refclk domain only.
module de0_cv_pll_reset_seq #(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned NUM_DOMAINS         = 3,
   parameter int unsigned STAGGER_CYCLES      = 8
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   reinit,
   input  logic                   pll_locked,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   sys_ready,
   output logic                   fault,
   output logic [7:0]             lock_lost
);

   // Last timer value used in RELEASE (release of the final domain).
   localparam int unsigned REL_SPAN = (NUM_DOMAINS - 1) * STAGGER_CYCLES;

   // One shared timer, sized for the largest count it ever has to reach.
   localparam int unsigned BOUND_A   = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                       RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned BOUND_B   = (BOUND_A > LOCK_TIMEOUT_CYCLES) ?
                                       BOUND_A : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned MAX_BOUND = (BOUND_B > REL_SPAN + 1) ? BOUND_B : REL_SPAN + 1;
   localparam int unsigned TW        = (MAX_BOUND < 2) ? 1 : $clog2(MAX_BOUND);
   localparam int unsigned RW        = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYCLES - 1);
   localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] REL_LAST = TW'(REL_SPAN);
   localparam logic [RW-1:0] RET_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t                 state_q,   state_n;
   logic [TW-1:0]          timer_q,   timer_n;
   logic [RW-1:0]          retries_q, retries_n;
   logic                   pll_rst_q, pll_rst_n;
   logic [NUM_DOMAINS-1:0] dom_q,     dom_n;
   logic                   ready_q,   ready_n;
   logic                   fault_q,   fault_n;
   logic [7:0]             lost_q,    lost_n;

   logic [1:0]             sync_q;
   logic                   lk;
   logic [NUM_DOMAINS-1:0] rel_hit;

   // Two-flop synchronizer for the asynchronous PLL locked signal.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   assign lk = sync_q[1];

   // Domain g is released on the edge where the RELEASE timer reaches g*STAGGER.
   for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_rel
      assign rel_hit[g] = ((32'(timer_q) + 32'd1) == (32'(g) * STAGGER_CYCLES));
   end

   // Next-state, counters and next registered outputs.
   always_comb begin
      state_n   = state_q;
      timer_n   = timer_q;
      retries_n = retries_q;
      dom_n     = dom_q;
      lost_n    = lost_q;
      pll_rst_n = 1'b1;
      ready_n   = 1'b0;
      fault_n   = 1'b0;

      case (state_q)
         S_RESET_PLL: begin
            if (timer_q == RST_LAST) begin
               state_n = S_WAIT_LOCK;
               timer_n = '0;
            end else begin
               timer_n = timer_q + TW'(1);
            end
         end

         S_WAIT_LOCK: begin
            if (lk) begin
               state_n = S_STABLE;
               timer_n = '0;
            end else if (timer_q == TO_LAST) begin
               timer_n   = '0;
               retries_n = retries_q + RW'(1);
               state_n   = (retries_n == RET_MAX) ? S_FAULT : S_RESET_PLL;
            end else begin
               timer_n = timer_q + TW'(1);
            end
         end

         S_STABLE: begin
            if (!lk) begin
               // glitch: restart the timeout window without spending a retry
               state_n = S_WAIT_LOCK;
               timer_n = '0;
            end else if (timer_q == STB_LAST) begin
               state_n  = S_RELEASE;
               timer_n  = '0;
               dom_n    = '1;
               dom_n[0] = 1'b0;
            end else begin
               timer_n = timer_q + TW'(1);
            end
         end

         S_RELEASE: begin
            if (!lk) begin
               state_n = S_RESET_PLL;
               timer_n = '0;
            end else if (timer_q == REL_LAST) begin
               state_n   = S_RUN;
               timer_n   = '0;
               retries_n = '0;
            end else begin
               timer_n = timer_q + TW'(1);
               dom_n   = dom_q & ~rel_hit;
            end
         end

         S_RUN: begin
            if (!lk) begin
               state_n = S_RESET_PLL;
               timer_n = '0;
               if (lost_q != 8'hFF) begin
                  lost_n = lost_q + 8'd1;
               end
            end
         end

         S_FAULT: begin
            state_n = S_FAULT;
         end

         default: begin
            state_n = S_RESET_PLL;
            timer_n = '0;
         end
      endcase

      // reinit restarts the whole sequence but keeps the lock-loss history
      if (reinit) begin
         state_n   = S_RESET_PLL;
         timer_n   = '0;
         retries_n = '0;
      end

      // registered outputs follow the state being entered
      pll_rst_n = (state_n == S_RESET_PLL) || (state_n == S_FAULT);
      fault_n   = (state_n == S_FAULT);
      ready_n   = (state_n == S_RUN);
      if ((state_n != S_RELEASE) && (state_n != S_RUN)) begin
         dom_n = '1;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= S_RESET_PLL;
         timer_q   <= '0;
         retries_q <= '0;
         pll_rst_q <= 1'b1;
         dom_q     <= '1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
         lost_q    <= '0;
      end else begin
         state_q   <= state_n;
         timer_q   <= timer_n;
         retries_q <= retries_n;
         pll_rst_q <= pll_rst_n;
         dom_q     <= dom_n;
         ready_q   <= ready_n;
         fault_q   <= fault_n;
         lost_q    <= lost_n;
      end
   end

   assign pll_rst    = pll_rst_q;
   assign domain_rst = dom_q;
   assign sys_ready  = ready_q;
   assign fault      = fault_q;
   assign lock_lost  = lost_q;

endmodule

// File: tb/tb_de0_cv_pll_reset_seq.sv
// Directed bench for de0_cv_pll_reset_seq with small timing parameters.
module tb_de0_cv_pll_reset_seq;

   localparam int unsigned ND = 3;

   logic          refclk;
   logic          rst;
   logic          reinit;
   logic          pll_locked;
   logic          pll_rst;
   logic [ND-1:0] domain_rst;
   logic          sys_ready;
   logic          fault;
   logic [7:0]    lock_lost;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      int         n;
      bit         r;
      bit         ri;
      bit         lk;
      bit         e_prst;
      logic [2:0] e_dom;
      bit         e_rdy;
      bit         e_flt;
      logic [7:0] e_lost;
   } vec_t;

   vec_t vecs[$];

   de0_cv_pll_reset_seq #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(20),
      .MAX_RETRIES        (2),
      .NUM_DOMAINS        (ND),
      .STAGGER_CYCLES     (2)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .reinit    (reinit),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .domain_rst(domain_rst),
      .sys_ready (sys_ready),
      .fault     (fault),
      .lock_lost (lock_lost)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   function automatic void add(input string name, input int n, input bit r, input bit ri,
                               input bit lk, input bit prst, input logic [2:0] dom,
                               input bit rdy, input bit flt, input logic [7:0] lost);
      vec_t v;
      v.name = name; v.n = n; v.r = r; v.ri = ri; v.lk = lk;
      v.e_prst = prst; v.e_dom = dom; v.e_rdy = rdy; v.e_flt = flt; v.e_lost = lost;
      vecs.push_back(v);
   endfunction

   // Drive inputs mid-cycle, let one rising edge happen, settle just after it.
   task automatic step(input bit r, input bit ri, input bit lk);
      @(negedge refclk);
      rst        = r;
      reinit     = ri;
      pll_locked = lk;
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string name, input bit e_prst, input logic [2:0] e_dom,
                        input bit e_rdy, input bit e_flt, input logic [7:0] e_lost);
      checks++;
      if ({pll_rst, domain_rst, sys_ready, fault, lock_lost} !==
          {e_prst, e_dom, e_rdy, e_flt, e_lost}) begin
         errors++;
         $display("FAIL %s @%0t: got pll_rst=%b domain_rst=%b sys_ready=%b fault=%b lock_lost=%0d, expected pll_rst=%b domain_rst=%b sys_ready=%b fault=%b lock_lost=%0d",
                  name, $time, pll_rst, domain_rst, sys_ready, fault, lock_lost,
                  e_prst, e_dom, e_rdy, e_flt, e_lost);
      end
   endtask

   initial begin
      bit         got;
      logic [7:0] exp_lost;

      rst        = 1'b1;
      reinit     = 1'b0;
      pll_locked = 1'b0;

      //   name            n   rst ri  lk  prst dom     rdy flt lost
      // power-up: reset, 4-cycle pll_rst, lock at cycle 10, staggered release
      add("t1_reset",      3,  1,  0,  0,  1,   3'b111, 0,  0,  8'd0);
      add("t1_prst",       3,  0,  0,  0,  1,   3'b111, 0,  0,  8'd0);
      add("t1_wait",       6,  0,  0,  0,  0,   3'b111, 0,  0,  8'd0);
      add("t1_lockup",     10, 0,  0,  1,  0,   3'b111, 0,  0,  8'd0);
      add("t1_rel0",       2,  0,  0,  1,  0,   3'b110, 0,  0,  8'd0);
      add("t1_rel1",       2,  0,  0,  1,  0,   3'b100, 0,  0,  8'd0);
      add("t1_rel2",       1,  0,  0,  1,  0,   3'b000, 0,  0,  8'd0);
      add("t1_run",        3,  0,  0,  1,  0,   3'b000, 1,  0,  8'd0);
      // lock loss in RUN: 2 sync cycles + 1, then full re-sequence
      add("t4_drop",       2,  0,  0,  0,  0,   3'b000, 1,  0,  8'd0);
      add("t4_lost",       1,  0,  0,  0,  1,   3'b111, 0,  0,  8'd1);
      add("t4_prst",       3,  0,  0,  1,  1,   3'b111, 0,  0,  8'd1);
      add("t4_wait",       9,  0,  0,  1,  0,   3'b111, 0,  0,  8'd1);
      add("t4_rel0",       2,  0,  0,  1,  0,   3'b110, 0,  0,  8'd1);
      add("t4_rel1",       2,  0,  0,  1,  0,   3'b100, 0,  0,  8'd1);
      add("t4_rel2",       1,  0,  0,  1,  0,   3'b000, 0,  0,  8'd1);
      add("t4_run",        2,  0,  0,  1,  0,   3'b000, 1,  0,  8'd1);
      // no lock: two attempts with 20-cycle waits, then FAULT; reinit clears it
      add("t2_reinit",     1,  0,  1,  0,  1,   3'b111, 0,  0,  8'd1);
      add("t2_prst_a",     3,  0,  0,  0,  1,   3'b111, 0,  0,  8'd1);
      add("t2_wait_a",     20, 0,  0,  0,  0,   3'b111, 0,  0,  8'd1);
      add("t2_prst_b",     4,  0,  0,  0,  1,   3'b111, 0,  0,  8'd1);
      add("t2_wait_b",     20, 0,  0,  0,  0,   3'b111, 0,  0,  8'd1);
      add("t2_fault",      6,  0,  0,  0,  1,   3'b111, 0,  1,  8'd1);
      add("t2_reinit_clr", 1,  0,  1,  0,  1,   3'b111, 0,  0,  8'd1);
      add("t2_prst_c",     3,  0,  0,  0,  1,   3'b111, 0,  0,  8'd1);
      // lock glitch at stable count 5: stability window restarts
      add("t3_lock",       6,  0,  0,  1,  0,   3'b111, 0,  0,  8'd1);
      add("t3_glitch",     1,  0,  0,  0,  0,   3'b111, 0,  0,  8'd1);
      add("t3_restab",     10, 0,  0,  1,  0,   3'b111, 0,  0,  8'd1);
      add("t3_rel0",       2,  0,  0,  1,  0,   3'b110, 0,  0,  8'd1);
      add("t3_rel1",       2,  0,  0,  1,  0,   3'b100, 0,  0,  8'd1);
      add("t3_rel2",       1,  0,  0,  1,  0,   3'b000, 0,  0,  8'd1);
      add("t3_run",        2,  0,  0,  1,  0,   3'b000, 1,  0,  8'd1);

      foreach (vecs[i]) begin
         for (int j = 0; j < vecs[i].n; j++) begin
            step(vecs[i].r, vecs[i].ri, vecs[i].lk);
            check(vecs[i].name, vecs[i].e_prst, vecs[i].e_dom, vecs[i].e_rdy,
                  vecs[i].e_flt, vecs[i].e_lost);
         end
      end

      // repeated lock losses from RUN: counter saturates at 255
      for (int k = 1; k <= 256; k++) begin
         for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0);
         exp_lost = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
         check("t5_loss", 1'b1, 3'b111, 1'b0, 1'b0, exp_lost);
         got = 1'b0;
         for (int c = 0; c < 60 && !got; c++) begin
            step(1'b0, 1'b0, 1'b1);
            if (sys_ready === 1'b1) got = 1'b1;
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL t5_relock: sys_ready=%b after 60 cycles, expected 1 (loss %0d)",
                     sys_ready, k);
         end
      end

      // reinit keeps the lock-loss count
      step(1'b0, 1'b1, 1'b1);
      check("t5_reinit_keeps", 1'b1, 3'b111, 1'b0, 1'b0, 8'd255);

      // run up to RELEASE with domain 0 already out of reset
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         step(1'b0, 1'b0, 1'b1);
         if (domain_rst === 3'b110) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL t6_reach_release: domain_rst=%b after 40 cycles, expected 110",
                  domain_rst);
      end
      check("t6_release0", 1'b0, 3'b110, 1'b0, 1'b0, 8'd255);

      // rst mid-RELEASE: everything back to reset values, including lock_lost
      step(1'b1, 1'b0, 1'b1);
      check("t6_rst", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b0, 1'b1);
         check("t6_prst", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0);
      end
      step(1'b0, 1'b0, 1'b1);
      check("t6_prst_end", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
